// File: rtl/shift_reg_universal.sv
// Universal shift register: shifts, rotates, arithmetic right shift, parallel load and clear.
// A word counter pulses word_done for one cycle after every WIDTH-th shift-class operation.
module shift_reg_universal #(
  parameter int              WIDTH     = 8,
  parameter logic [WIDTH-1:0] RESET_VAL = '0,
  localparam int             CW        = (WIDTH > 2) ? $clog2(WIDTH) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [2:0]       mode,
  input  logic             serial_in_r,
  input  logic             serial_in_l,
  input  logic [WIDTH-1:0] par_in,
  output logic [WIDTH-1:0] q,
  output logic             serial_out_r,
  output logic             serial_out_l,
  output logic [CW-1:0]    shift_cnt,
  output logic             word_done
);

  typedef enum logic [2:0] {
    MODE_HOLD  = 3'b000,
    MODE_SHR   = 3'b001,
    MODE_SHL   = 3'b010,
    MODE_ROR   = 3'b011,
    MODE_ROL   = 3'b100,
    MODE_LOAD  = 3'b101,
    MODE_CLEAR = 3'b110,
    MODE_ASR   = 3'b111
  } mode_e;

  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  logic [WIDTH-1:0] q_q, q_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             done_q, done_d;
  logic             shift_op;

  always_comb begin
    q_d      = q_q;
    shift_op = 1'b0;
    case (mode_e'(mode))
      MODE_SHR: begin
        q_d      = {serial_in_r, q_q[WIDTH-1:1]};
        shift_op = 1'b1;
      end
      MODE_SHL: begin
        q_d      = {q_q[WIDTH-2:0], serial_in_l};
        shift_op = 1'b1;
      end
      MODE_ROR: begin
        q_d      = {q_q[0], q_q[WIDTH-1:1]};
        shift_op = 1'b1;
      end
      MODE_ROL: begin
        q_d      = {q_q[WIDTH-2:0], q_q[WIDTH-1]};
        shift_op = 1'b1;
      end
      MODE_LOAD:  q_d = par_in;
      MODE_CLEAR: q_d = '0;
      MODE_ASR: begin
        q_d      = {q_q[WIDTH-1], q_q[WIDTH-1:1]};
        shift_op = 1'b1;
      end
      default: q_d = q_q;
    endcase
  end

  // Load and clear restart the word; hold keeps the count but never pulses.
  always_comb begin
    cnt_d  = cnt_q;
    done_d = 1'b0;
    if (en) begin
      if (shift_op) begin
        if (cnt_q == CNT_LAST) begin
          cnt_d  = '0;
          done_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end else if (mode == MODE_LOAD || mode == MODE_CLEAR) begin
        cnt_d = '0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_q    <= RESET_VAL;
      cnt_q  <= '0;
      done_q <= 1'b0;
    end else begin
      if (en) begin
        q_q <= q_d;
      end
      cnt_q  <= cnt_d;
      done_q <= done_d;
    end
  end

  assign q            = q_q;
  assign shift_cnt    = cnt_q;
  assign word_done    = done_q;
  assign serial_out_r = q_q[0];
  assign serial_out_l = q_q[WIDTH-1];

endmodule

// File: tb/tb_shift_reg_universal.sv
// Directed-vector bench for shift_reg_universal (WIDTH=8) with hand-computed expectations.
module tb_shift_reg_universal;

  localparam int WIDTH = 8;
  localparam int CW    = 3;

  logic             clk;
  logic             rst_n;
  logic             en;
  logic [2:0]       mode;
  logic             serial_in_r;
  logic             serial_in_l;
  logic [WIDTH-1:0] par_in;
  logic [WIDTH-1:0] q;
  logic             serial_out_r;
  logic             serial_out_l;
  logic [CW-1:0]    shift_cnt;
  logic             word_done;

  int checks = 0;
  int errors = 0;
  int pulses;

  shift_reg_universal #(.WIDTH(WIDTH), .RESET_VAL(8'h00)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .en           (en),
    .mode         (mode),
    .serial_in_r  (serial_in_r),
    .serial_in_l  (serial_in_l),
    .par_in       (par_in),
    .q            (q),
    .serial_out_r (serial_out_r),
    .serial_out_l (serial_out_l),
    .shift_cnt    (shift_cnt),
    .word_done    (word_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Apply one operation for one edge, then settle just past the edge.
  task automatic step(input logic e, input logic [2:0] m);
    en   = e;
    mode = m;
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [WIDTH-1:0] v);
    par_in = v;
    step(1'b1, 3'b101);
  endtask

  initial begin
    rst_n = 1'b0; en = 1'b0; mode = 3'b000;
    serial_in_r = 1'b0; serial_in_l = 1'b0; par_in = '0;
    #12;
    chk("reset_q", 32'(q), 32'h00);
    chk("reset_cnt", 32'(shift_cnt), 0);
    chk("reset_done", 32'(word_done), 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Reset mid-sequence
    load(8'hFF);
    serial_in_r = 1'b0;
    repeat (3) step(1'b1, 3'b001);
    chk("pre_rst_q", 32'(q), 32'h1F);
    chk("pre_rst_cnt", 32'(shift_cnt), 3);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_q", 32'(q), 32'h00);
    chk("async_rst_cnt", 32'(shift_cnt), 0);
    chk("async_rst_done", 32'(word_done), 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Right shift
    load(8'hA5);
    serial_in_r = 1'b1;
    step(1'b1, 3'b001); chk("shr1_q", 32'(q), 32'hD2); chk("shr1_sor", 32'(serial_out_r), 0);
    step(1'b1, 3'b001); chk("shr2_q", 32'(q), 32'hE9); chk("shr2_sor", 32'(serial_out_r), 1);
    step(1'b1, 3'b001); chk("shr3_q", 32'(q), 32'hF4); chk("shr3_sor", 32'(serial_out_r), 0);
    step(1'b1, 3'b001); chk("shr4_q", 32'(q), 32'hFA); chk("shr4_sor", 32'(serial_out_r), 0);
    chk("shr_cnt", 32'(shift_cnt), 4);
    step(1'b1, 3'b000);
    chk("hold_q", 32'(q), 32'hFA);
    chk("hold_cnt", 32'(shift_cnt), 4);

    // Rotate left and word pulse
    load(8'h81);
    step(1'b1, 3'b100);
    chk("rol1_q", 32'(q), 32'h03);
    chk("rol1_done", 32'(word_done), 0);
    for (int i = 2; i <= 8; i++) begin
      step(1'b1, 3'b100);
      chk("rol_done", 32'(word_done), (i == 8) ? 1 : 0);
    end
    chk("rol8_q", 32'(q), 32'h81);
    chk("rol8_cnt", 32'(shift_cnt), 0);
    pulses = 0;
    for (int i = 1; i <= 8; i++) begin
      step(1'b1, 3'b100);
      if (word_done) pulses++;
      chk("rol2_done", 32'(word_done), (i == 8) ? 1 : 0);
    end
    chk("rol2_pulses", 32'(pulses), 1);
    step(1'b1, 3'b000);
    chk("pulse_end", 32'(word_done), 0);

    // Rotate right
    load(8'h01);
    step(1'b1, 3'b011);
    chk("ror_q", 32'(q), 32'h80);

    // Arithmetic right
    load(8'h90);
    step(1'b1, 3'b111); chk("asr1_q", 32'(q), 32'hC8);
    step(1'b1, 3'b111); chk("asr2_q", 32'(q), 32'hE4);
    load(8'h70);
    step(1'b1, 3'b111); chk("asr3_q", 32'(q), 32'h38);

    // Enable, hold and reload at count WIDTH-1
    load(8'h00);
    serial_in_r = 1'b1;
    repeat (7) step(1'b1, 3'b001);
    chk("en_pre_q", 32'(q), 32'hFE);
    chk("en_pre_cnt", 32'(shift_cnt), 7);
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 3'b001);
      chk("en0_q", 32'(q), 32'hFE);
      chk("en0_cnt", 32'(shift_cnt), 7);
      chk("en0_done", 32'(word_done), 0);
    end
    load(8'h3C);
    chk("reload_q", 32'(q), 32'h3C);
    chk("reload_cnt", 32'(shift_cnt), 0);
    chk("reload_done", 32'(word_done), 0);
    step(1'b1, 3'b000);
    chk("reload_done2", 32'(word_done), 0);

    // Shift left then clear
    step(1'b1, 3'b110);
    serial_in_l = 1'b1;
    repeat (3) step(1'b1, 3'b010);
    chk("shl_q", 32'(q), 32'h07);
    chk("shl_sol", 32'(serial_out_l), 0);
    chk("shl_cnt", 32'(shift_cnt), 3);
    step(1'b1, 3'b110);
    chk("clr_q", 32'(q), 32'h00);
    chk("clr_cnt", 32'(shift_cnt), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/shift_reg_universal.md
Name: shift_reg_universal

Overview:
- Parametrised universal shift register; next generation of the team's fixed 4-bit serial-in/serial-out right shifter.
- Adds:
  - configurable width
  - async active-low reset
  - clock enable
  - left/right shift, rotate, arithmetic right shift, parallel load and clear
  - a word-boundary counter that flags each completed WIDTH-bit shift sequence.
- Used as a serialiser/deserialiser front end and as a general data-path shifter.

Parameters:
- WIDTH, 8, register width in bits; must be >= 2.
- RESET_VAL, 0, value loaded into q on reset; WIDTH bits.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- en  input  1  clock enable; when 0, all state is held.
- mode  input  3  operation select (see Behaviour).
- serial_in_r  input  1  bit entering q[WIDTH-1] on shift right.
- serial_in_l  input  1  bit entering q[0] on shift left.
- par_in  input  WIDTH  parallel load data.
- q  output  WIDTH  register contents.
- serial_out_r  output  1  equals q[0], combinational from q.
- serial_out_l  output  1  equals q[WIDTH-1], combinational from q.
- shift_cnt  output  CW  shifts since last load/clear/wrap; CW = $clog2(WIDTH), minimum 1.
- word_done  output  1  one-cycle pulse after the WIDTH-th shift-class operation.

Behaviour:
- One clock (clk). Reset is asynchronous and active-low (rst_n).
- Reset (rst_n=0, immediate, independent of clk/en):
  - q = RESET_VAL
  - shift_cnt = 0
  - word_done = 0
- Reset deassertion takes effect at the next rising clk edge. Reset mid-sequence discards the partial count.
- All updates occur on the rising clk edge, only when en=1.
- With en=0, q and shift_cnt hold and word_done is driven 0.
- mode encoding (en=1):
  - 000 hold: q unchanged; not shift-class.
  - 001 shift right: q <= {serial_in_r, q[WIDTH-1:1]}.
  - 010 shift left: q <= {q[WIDTH-2:0], serial_in_l}.
  - 011 rotate right: q <= {q[0], q[WIDTH-1:1]}.
  - 100 rotate left: q <= {q[WIDTH-2:0], q[WIDTH-1]}.
  - 101 parallel load: q <= par_in.
  - 110 clear: q <= 0. This is all zeros, not RESET_VAL.
  - 111 arithmetic shift right: q <= {q[WIDTH-1], q[WIDTH-1:1]}.
- Shift-class modes: 001, 010, 011, 100, 111.
- Counter, on each enabled shift-class edge:
  - If shift_cnt == WIDTH-1: shift_cnt <= 0 and word_done <= 1.
  - Else: shift_cnt <= shift_cnt+1 and word_done <= 0.
- Load (101) and clear (110) set shift_cnt <= 0 and word_done <= 0, including when the count is at WIDTH-1.
- Hold (000) with en=1 keeps shift_cnt and drives word_done <= 0.
- word_done is registered and high for exactly one cycle, in the cycle following the completing edge.
- Back-to-back words (WIDTH shifts, then WIDTH more) produce one word_done pulse per word with no gap cycle required.
- Mixing shift directions within a word is legal; the counter counts operations, not direction.
- Latency:
  - q, shift_cnt and word_done reflect an operation one edge after it is sampled.
  - serial_out_r and serial_out_l have zero latency from q.
- Unknown or X mode: no requirement beyond not corrupting reset behaviour.
- Sole state: q, shift_cnt, word_done. No other storage.

Test Plan:
- (WIDTH=8 for all.) Reset mid-run: after 3 shifts, drop rst_n between edges -> q=8'h00, shift_cnt=0, word_done=0 immediately, before the next edge.
- Right shift: load 8'hA5, then 4x mode 001 with serial_in_r=1:
  - q = 8'hD2, 8'hE9, 8'hF4, 8'hFA
  - serial_out_r = 0, 1, 0, 0 after each edge
  - shift_cnt = 4
- Rotate left / word pulse: load 8'h81, then 8x mode 100:
  - q after edge 1 = 8'h03
  - after edge 8, q=8'h81 and shift_cnt=0
  - word_done=1 for exactly the one cycle after edge 8
  - 8 further rotates give a second single pulse.
- Arithmetic right: load 8'h90, then 2x mode 111 -> q = 8'hC8, then 8'hE4. Load 8'h70, then 1x 111 -> q = 8'h38.
- Enable/hold/reload:
  - After 7 shifts (shift_cnt=7), en=0 with mode=001 for 3 cycles -> q and shift_cnt unchanged, word_done=0.
  - Then mode 101 with par_in=8'h3C -> q=8'h3C, shift_cnt=0, no word_done pulse.
- Shift left with clear: from 8'h00, 3x mode 010 with serial_in_l=1 -> q=8'h07 and serial_out_l=0. Then mode 110 -> q=8'h00, shift_cnt=0.
